// File: rtl/udp_rx_payload_packer.sv
// udp_rx_payload_packer
//   Drains the UDP receive stage's byte-wide payload FIFO once a frame is
//   flagged complete. It packs the bytes big-endian into 32-bit words on a
//   valid/ready stream with sof/eof/keep. The FIFO is always emptied at frame
//   end so the upstream stage can leave its end state. A mid-frame underrun
//   is cut short by a timeout, which ends the frame with an error.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   udp_rec_data_valid       frame-complete level from the receive stage
//   udp_rec_data_length      UDP length field (header included)
//   udp_rx_fifo_empty        payload FIFO empty
//   udp_rec_ram_rdata        FIFO data, valid one cycle after a pop
//   udp_rec_ram_read_en      FIFO pop
//   out_data/keep/sof/eof/err/valid, out_ready   packed word stream
//   frame_cnt                frames emitted without error (wraps)
//   flush_cnt                surplus bytes discarded (saturates)
//
// state    | meaning
// IDLE     | waiting for udp_rec_data_valid
// READ     | popping payload bytes and packing words
// FLUSH    | discarding any bytes left in the FIFO
// WAIT_CLR | waiting for udp_rec_data_valid to drop
module udp_rx_payload_packer #(
    parameter int HDR_BYTES = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rec_data_valid,
    input  logic [15:0] udp_rec_data_length,
    input  logic        udp_rx_fifo_empty,
    input  logic [7:0]  udp_rec_ram_rdata,
    output logic        udp_rec_ram_read_en,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_cnt,
    output logic [15:0] flush_cnt
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
    localparam logic [15:0]   HDR      = 16'(HDR_BYTES);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, WAIT_CLR} state_t;

    state_t        state;
    logic [15:0]   remaining;
    logic [31:0]   acc;
    logic [2:0]    acc_cnt;
    logic          inflight;
    logic          first;
    logic          done;
    logic [TW-1:0] tmo_left;

    logic [15:0]   payload_len;
    logic [31:0]   acc_eff;
    logic [2:0]    cnt_eff;
    logic [3:0]    keep_eff;
    logic          xfer;
    logic          can_move;
    logic          tmo_hit;
    logic          word_done;
    logic          move;
    logic          move_eof;
    logic          rd_en;

    // The byte returning this cycle is merged combinationally, so a full word
    // can leave in the same cycle its fourth byte lands. That is what allows
    // one byte per cycle without a bubble at word boundaries.
    always_comb begin
        payload_len = (udp_rec_data_length > HDR) ? (udp_rec_data_length - HDR) : 16'd0;

        acc_eff = acc;
        if (inflight && state == READ) begin
            case (acc_cnt[1:0])
                2'd0:    acc_eff[31:24] = udp_rec_ram_rdata;
                2'd1:    acc_eff[23:16] = udp_rec_ram_rdata;
                2'd2:    acc_eff[15:8]  = udp_rec_ram_rdata;
                default: acc_eff[7:0]   = udp_rec_ram_rdata;
            endcase
        end
        cnt_eff = acc_cnt + {2'b00, inflight && state == READ};

        case (cnt_eff)
            3'd1:    keep_eff = 4'b1000;
            3'd2:    keep_eff = 4'b1100;
            3'd3:    keep_eff = 4'b1110;
            3'd4:    keep_eff = 4'b1111;
            default: keep_eff = 4'b0000;
        endcase

        xfer      = out_valid && out_ready;
        can_move  = !out_valid || out_ready;
        tmo_hit   = (tmo_left == '0);
        word_done = (cnt_eff == 3'd4) || (remaining == 16'd0 && cnt_eff != 3'd0);
        move      = (state == READ) && !done && can_move && (tmo_hit || word_done);
        // No pop happens when remaining is already zero, so the moved word
        // then leaves nothing behind it.
        move_eof  = tmo_hit || (remaining == 16'd0);

        // Occupancy counts the word leaving this cycle as already gone, which
        // keeps accumulator space for the byte being requested.
        rd_en = 1'b0;
        case (state)
            READ:    rd_en = !done && !tmo_hit && !udp_rx_fifo_empty && remaining != 16'd0
                             && ((move ? 3'd0 : cnt_eff) < 3'd4);
            FLUSH:   rd_en = !udp_rx_fifo_empty;
            default: rd_en = 1'b0;
        endcase
    end

    assign udp_rec_ram_read_en = rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 16'd0;
            acc       <= 32'd0;
            acc_cnt   <= 3'd0;
            inflight  <= 1'b0;
            first     <= 1'b0;
            done      <= 1'b0;
            tmo_left  <= TMO_LOAD;
            out_data  <= 32'd0;
            out_keep  <= 4'd0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            inflight <= rd_en;

            if (move) begin
                out_valid <= 1'b1;
                out_data  <= acc_eff;
                out_keep  <= keep_eff;
                out_sof   <= first;
                out_eof   <= move_eof;
                out_err   <= tmo_hit;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (udp_rec_data_valid) begin
                        remaining <= payload_len;
                        acc       <= 32'd0;
                        acc_cnt   <= 3'd0;
                        first     <= 1'b1;
                        done      <= 1'b0;
                        tmo_left  <= TMO_LOAD;
                        state     <= (payload_len != 16'd0) ? READ : FLUSH;
                    end
                end

                READ: begin
                    if (rd_en) begin
                        remaining <= remaining - 16'd1;
                        tmo_left  <= TMO_LOAD;
                    end else if (udp_rx_fifo_empty && remaining != 16'd0 && !done && !tmo_hit) begin
                        tmo_left <= tmo_left - TW'(1);
                    end

                    if (move) begin
                        acc     <= 32'd0;
                        acc_cnt <= 3'd0;
                        first   <= 1'b0;
                        done    <= move_eof;
                    end else begin
                        acc     <= acc_eff;
                        acc_cnt <= cnt_eff;
                    end

                    // Stay here until the final word is taken, so the output
                    // register never holds a word from an older frame.
                    if (xfer && out_eof) begin
                        state <= FLUSH;
                        if (!out_err) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end

                FLUSH: begin
                    if (rd_en && flush_cnt != 16'hFFFF) begin
                        flush_cnt <= flush_cnt + 16'd1;
                    end
                    if (udp_rx_fifo_empty && !inflight) begin
                        state <= WAIT_CLR;
                    end
                end

                WAIT_CLR: begin
                    if (!udp_rec_data_valid) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_payload_packer.sv
// Testbench for udp_rx_payload_packer: byte FIFO model, scoreboard of expected
// output words, and checks on counters and reset behaviour.
module tb_udp_rx_payload_packer;

    localparam int HDR = 8;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] len = 16'd0;
    logic        empty = 1'b1;
    logic [7:0]  rdata = 8'd0;
    logic        rd_en;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_sof, out_eof, out_err, out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] frame_cnt, flush_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        sof;
        logic        eof;
        logic        err;
    } word_t;

    word_t      sb[$];
    logic [7:0] fifo_q[$];
    int         total = 0;
    int         bad = 0;
    int         ready_mode = 0;
    int         cyc = 0;
    logic       pop_pend = 1'b0;
    int         exp_frames = 0;
    int         exp_flush = 0;
    logic       stall_prev = 1'b0;
    word_t      held;
    word_t      cur;
    word_t      exp_w;

    udp_rx_payload_packer #(.HDR_BYTES(HDR), .TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .udp_rec_data_valid  (valid),
        .udp_rec_data_length (len),
        .udp_rx_fifo_empty   (empty),
        .udp_rec_ram_rdata   (rdata),
        .udp_rec_ram_read_en (rd_en),
        .out_data            (out_data),
        .out_keep            (out_keep),
        .out_sof             (out_sof),
        .out_eof             (out_eof),
        .out_err             (out_err),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .frame_cnt           (frame_cnt),
        .flush_cnt           (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] keep_of(input int n);
        case (n)
            1:       return 4'b1000;
            2:       return 4'b1100;
            3:       return 4'b1110;
            4:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // FIFO model and output monitor. All inputs settle before +2, where the
    // pop request is sampled; the popped byte is presented one cycle later.
    always @(negedge clk) begin
        cyc++;
        if (pop_pend && fifo_q.size() > 0) rdata = fifo_q.pop_front();
        else rdata = 8'hEE;
        out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        #1;
        empty = (fifo_q.size() == 0);
        #1;
        pop_pend = rd_en && !rst;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            cur = {out_data, out_keep, out_sof, out_eof, out_err};
            if (stall_prev) chk("stall_hold", cur, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("data", out_data, exp_w.d);
                    chk("keep", out_keep, exp_w.k);
                    chk("sof",  out_sof,  exp_w.sof);
                    chk("eof",  out_eof,  exp_w.eof);
                    chk("err",  out_err,  exp_w.err);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = cur;
        end
    end

    // Expected words for a frame of length field l with nbytes in the FIFO,
    // bytes b0, b0+1, ... A short supply ends in a timeout error word.
    task automatic build_expected(input int l, input int nbytes, input logic [7:0] b0);
        int          p;
        int          used;
        bit          tmo;
        int          cnt;
        logic [31:0] w;
        bit          sof_next;
        word_t       e;
        p        = (l > HDR) ? l - HDR : 0;
        used     = (nbytes < p) ? nbytes : p;
        tmo      = (nbytes < p);
        cnt      = 0;
        w        = 32'd0;
        sof_next = 1'b1;
        for (int i = 0; i < used; i++) begin
            w[31 - 8*cnt -: 8] = b0 + 8'(i);
            cnt++;
            if (cnt == 4) begin
                e.d = w; e.k = 4'hF; e.sof = sof_next;
                e.eof = (!tmo && (i + 1 == p)); e.err = 1'b0;
                sb.push_back(e);
                sof_next = 1'b0; cnt = 0; w = 32'd0;
            end
        end
        if (tmo || cnt > 0) begin
            e.d = w; e.k = keep_of(cnt); e.sof = sof_next; e.eof = 1'b1; e.err = tmo;
            sb.push_back(e);
        end
        if (nbytes > p) exp_flush += nbytes - p;
        if (p > 0 && !tmo) exp_frames++;
    endtask

    task automatic send_frame(input int l, input int nbytes, input logic [7:0] b0, input int mode);
        int budget;
        build_expected(l, nbytes, b0);
        @(negedge clk);
        ready_mode = mode;
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(b0 + 8'(i));
        len   = 16'(l);
        valid = 1'b1;
        budget = 0;
        while (!(sb.size() == 0 && fifo_q.size() == 0 && !pop_pend) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_timeout", budget >= 3000, 0);
        repeat (4) @(negedge clk);
        chk("fifo_empty", fifo_q.size(), 0);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("flush_cnt", flush_cnt, exp_flush);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_rd_en", rd_en, 0);
        ready_mode = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},   out_valid, 0);
        chk({tag, "_data"},    out_data,  0);
        chk({tag, "_keep"},    out_keep,  0);
        chk({tag, "_flags"},   {out_sof, out_eof, out_err}, 0);
        chk({tag, "_frames"},  frame_cnt, 0);
        chk({tag, "_flushes"}, flush_cnt, 0);
        chk({tag, "_rd_en"},   rd_en,     0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_frame(20, 12, 8'h01, 0);   // three full words
        send_frame(15,  7, 8'hA0, 0);   // full + 3-byte tail
        send_frame( 9,  1, 8'h55, 0);   // single-byte frame, sof=eof
        send_frame( 8,  2, 8'hC0, 0);   // zero payload, FIFO still flushed
        send_frame(16, 11, 8'h30, 0);   // 3 surplus bytes
        send_frame(24, 16, 8'h40, 1);   // back-pressure 1 on / 3 off
        send_frame(18,  6, 8'h70, 0);   // underrun -> timeout error word

        // Reset in the middle of a stalled frame.
        build_expected(20, 12, 8'h80);
        @(negedge clk);
        ready_mode = 1;
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'h80 + 8'(i));
        len   = 16'd20;
        valid = 1'b1;
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        fifo_q.delete();
        sb.delete();
        exp_frames = 0;
        exp_flush  = 0;
        #3;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        send_frame(13, 5, 8'h90, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
